// File: rtl/uart_cmd_framer.sv
// Command framer behind the UART receiver: hunts SYNC, assembles {HI,LO},
// validates an XOR checksum and hands one command at a time to the consumer.
module uart_cmd_framer #(
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         TMO_CYCLES = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        ovr_err
);

    localparam int            CW       = $clog2(TMO_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, GET_CHK} state_t;

    state_t        state, state_d;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    hi_reg, lo_reg;
    logic          hi_ld, lo_ld, frame_ok, frame_bad, tmo_fire;

    // The receiver drops rdy on the next edge, so acking every rdy cycle is safe.
    assign clr_rdy = rx_rdy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        hi_ld     = 1'b0;
        lo_ld     = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rdy && rx_data == SYNC) state_d = GET_HI;
            end
            GET_HI: begin
                if (rx_rdy) begin
                    hi_ld   = 1'b1;
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (rx_rdy) begin
                    lo_ld   = 1'b1;
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_rdy) begin
                    state_d   = IDLE;
                    frame_ok  = (rx_data == (hi_reg ^ lo_reg));
                    frame_bad = ~frame_ok;
                end
            end
            default: state_d = IDLE;
        endcase
        // An accepted byte in the expiry cycle wins over the timeout.
        if (state != IDLE && !rx_rdy && tmo_cnt == TMO_LAST) begin
            tmo_fire = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            chk_err <= 1'b0;
            tmo_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (state == IDLE || rx_rdy || tmo_fire) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_cnt + CW'(1);
            if (hi_ld) hi_reg <= rx_data;
            if (lo_ld) lo_reg <= rx_data;
            chk_err <= frame_bad;
            tmo_err <= tmo_fire;
            ovr_err <= frame_ok & cmd_rdy & ~clr_cmd_rdy;
            // Set beats clear; cmd itself is only replaced by a newer valid frame.
            if (frame_ok) begin
                cmd     <= {hi_reg, lo_reg};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: framing, checksum, timeout boundary,
// overrun/collision and reset mid-frame, with hand-computed expectations.
module tb_uart_cmd_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        chk_err;
    logic        tmo_err;
    logic        ovr_err;

    int vectors     = 0;
    int miscompares = 0;
    int n_chk = 0, n_tmo = 0, n_ovr = 0;

    uart_cmd_framer #(.SYNC(8'hA5), .TMO_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .chk_err     (chk_err),
        .tmo_err     (tmo_err),
        .ovr_err     (ovr_err)
    );

    always #5 clk = ~clk;

    // Total error pulses seen over the run, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_err) n_chk++;
        if (tmo_err) n_tmo++;
        if (ovr_err) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is taken on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1;
        check("clr_rdy_follows_rdy", {31'd0, clr_rdy}, 32'd1);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck);
        send_byte(8'hA5);
        send_byte(hi);
        send_byte(lo);
        send_byte(ck);
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd",     {16'd0, cmd}, 32'h0);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_errs",    {29'd0, chk_err, tmo_err, ovr_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // valid frame, then consume
        send_frame(8'h12, 8'h34, 8'h26);
        check("valid_cmd",     {16'd0, cmd}, 32'h1234);
        check("valid_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("valid_errs",    {29'd0, chk_err, tmo_err, ovr_err}, 32'd0);
        clear_cmd();
        check("clr_cmd_rdy",  {31'd0, cmd_rdy}, 32'd0);
        check("clr_cmd_hold", {16'd0, cmd}, 32'h1234);

        // bad checksum, then recovery
        send_frame(8'h12, 8'h34, 8'h00);
        check("bad_chk_err", {31'd0, chk_err}, 32'd1);
        check("bad_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("bad_cmd",     {16'd0, cmd}, 32'h1234);
        @(negedge clk);
        check("bad_chk_pulse", {31'd0, chk_err}, 32'd0);
        send_frame(8'hAB, 8'hCD, 8'h66);
        check("recover_cmd", {16'd0, cmd}, 32'hABCD);
        check("recover_rdy", {31'd0, cmd_rdy}, 32'd1);
        clear_cmd();

        // garbage before sync is dropped silently
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("garbage_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_frame(8'h00, 8'h01, 8'h01);
        check("garbage_cmd", {16'd0, cmd}, 32'h0001);
        check("garbage_rdy2", {31'd0, cmd_rdy}, 32'd1);
        clear_cmd();

        // SYNC inside a frame is data
        send_frame(8'hA5, 8'h12, 8'hB7);
        check("sync_as_data", {16'd0, cmd}, 32'hA512);
        clear_cmd();

        // timeout: 12 accepted at edge E; tmo_err visible just after E+16
        send_byte(8'hA5); send_byte(8'h12);
        repeat (15) @(negedge clk);
        check("tmo_not_yet", {31'd0, tmo_err}, 32'd0);
        @(negedge clk);
        check("tmo_pulse", {31'd0, tmo_err}, 32'd1);
        @(negedge clk);
        check("tmo_one_cycle", {31'd0, tmo_err}, 32'd0);
        send_byte(8'h34); send_byte(8'h26);  // back in IDLE: discarded
        check("tmo_idle_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("tmo_idle_chk", {31'd0, chk_err}, 32'd0);
        send_frame(8'h00, 8'h02, 8'h02);
        check("tmo_next_cmd", {16'd0, cmd}, 32'h0002);
        clear_cmd();

        // byte accepted in the expiry cycle keeps the frame alive
        send_byte(8'hA5); send_byte(8'h12);
        repeat (15) @(negedge clk);
        send_byte(8'h34);
        check("tmo_boundary_no_err", {31'd0, tmo_err}, 32'd0);
        send_byte(8'h26);
        check("tmo_boundary_cmd", {16'd0, cmd}, 32'h1234);
        check("tmo_boundary_rdy", {31'd0, cmd_rdy}, 32'd1);
        clear_cmd();

        // overrun
        send_frame(8'h11, 8'h22, 8'h33);
        check("ovr_first_none", {31'd0, ovr_err}, 32'd0);
        send_frame(8'h33, 8'h44, 8'h77);
        check("ovr_pulse", {31'd0, ovr_err}, 32'd1);
        check("ovr_cmd",   {16'd0, cmd}, 32'h3344);
        @(negedge clk);
        check("ovr_one_cycle", {31'd0, ovr_err}, 32'd0);
        check("ovr_rdy_kept",  {31'd0, cmd_rdy}, 32'd1);

        // clear collides with the CHK accept: set wins, no overrun
        send_byte(8'hA5); send_byte(8'h55); send_byte(8'h66);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h33);
        clr_cmd_rdy = 1'b0;
        check("coll_no_ovr", {31'd0, ovr_err}, 32'd0);
        check("coll_rdy",    {31'd0, cmd_rdy}, 32'd1);
        check("coll_cmd",    {16'd0, cmd}, 32'h5566);

        // reset mid-frame
        send_byte(8'hA5); send_byte(8'h12);
        rst = 1'b1; rx_data = 8'h34; rx_rdy = 1'b1;
        #1;
        check("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
        @(negedge clk);
        check("rst_mid_cmd",  {16'd0, cmd}, 32'h0);
        check("rst_mid_rdy",  {31'd0, cmd_rdy}, 32'd0);
        check("rst_mid_errs", {29'd0, chk_err, tmo_err, ovr_err}, 32'd0);
        rx_rdy = 1'b0; rst = 1'b0;
        send_byte(8'h34); send_byte(8'h26);
        check("rst_tail_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_tail_cmd", {16'd0, cmd}, 32'h0);
        repeat (20) @(negedge clk);

        // whole run: exactly one pulse of each error kind
        check("total_chk", n_chk, 32'd1);
        check("total_tmo", n_tmo, 32'd1);
        check("total_ovr", n_ovr, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Command framer that sits directly behind the UART receiver and sequences it. It drains received bytes through the receiver's `rdy`/`clr_rdy` handshake, hunts for a sync byte, and assembles a 16-bit command from the next two bytes. It validates each frame with an XOR checksum and aborts partial frames on an inter-byte timeout. It presents one command at a time to the command processor with a ready/clear handshake and flags checksum, timeout and overrun errors.

## Interface
- `SYNC`, default 8'hA5: frame sync byte.
- `TMO_CYCLES`, default 131072: inter-byte timeout in clk cycles. Legal range is ≥ 2. The counter width is $clog2(TMO_CYCLES).
- `clk` input 1: system clock. The block uses only this one clock.
- `rst` input 1: synchronous, active-high reset, sampled on posedge `clk`.
- `rx_data` input 8: byte from the UART receiver.
- `rx_rdy` input 1: receiver byte-valid flag, registered in the receiver.
- `clr_rdy` output 1: consumes the receiver byte.
- `clr_cmd_rdy` input 1: command processor has taken `cmd`.
- `cmd` output 16: last valid command, {high byte, low byte}.
- `cmd_rdy` output 1: `cmd` holds an unconsumed valid command.
- `chk_err` output 1: one-cycle pulse when a frame is dropped for a bad checksum.
- `tmo_err` output 1: one-cycle pulse when a partial frame is aborted by timeout.
- `ovr_err` output 1: one-cycle pulse when a new command overwrote an unconsumed one.

## Operation
- **Frame format:** `SYNC`, HI, LO, CHK. The frame is valid iff CHK == HI ^ LO.
- **Byte acceptance:**
  - `clr_rdy` = `rx_rdy` & ~`rst`, and is combinational.
  - A byte is accepted in every cycle where `rx_rdy`=1.
  - The receiver drops `rdy` on the next edge, so no byte is accepted twice.
- **States:** IDLE, GET_HI, GET_LO, GET_CHK.
- **IDLE:**
  - An accepted byte equal to `SYNC` moves to GET_HI.
  - Any other byte is consumed and discarded, with no error.
- **GET_HI:** the accepted byte is latched into `hi_reg`, then move to GET_LO. A byte equal to `SYNC` is treated as data here, not as a resync.
- **GET_LO:** the accepted byte is latched into `lo_reg`, then move to GET_CHK.
- **GET_CHK:** on an accepted byte, move to IDLE. Then:
  - If byte == `hi_reg`^`lo_reg`: `cmd` <= {`hi_reg`,`lo_reg`} and `cmd_rdy` <= 1. If `cmd_rdy` was already 1 and `clr_cmd_rdy`=0 that cycle, also pulse `ovr_err`.
  - Otherwise pulse `chk_err`. `cmd` and `cmd_rdy` are unchanged.
- **Timeout:**
  - `tmo_cnt` is cleared in IDLE and on every accepted byte.
  - Otherwise it increments while the state is not IDLE.
  - When `tmo_cnt` == `TMO_CYCLES`-1 and no byte is accepted that cycle: move to IDLE and pulse `tmo_err`.
  - If a byte is accepted in the same cycle as expiry, the byte is processed normally and there is no timeout.
- **`cmd_rdy` flop:**
  - It is set by a valid frame and cleared by `clr_cmd_rdy`.
  - Simultaneous set and clear: set wins, and there is no `ovr_err`.
- **`cmd` hold:** `cmd` holds its value until the next valid frame. `clr_cmd_rdy` does not clear `cmd`.
- **Reset:**
  - Reset values: state = IDLE, `cmd` = 16'h0000, `cmd_rdy` = 0, `chk_err` = `tmo_err` = `ovr_err` = 0, `tmo_cnt` = 0, `hi_reg` = `lo_reg` = 0.
  - Reset mid-frame discards the partial frame and pulses no error.
  - While `rst`=1, `clr_rdy`=0.

## Timing
- `clr_rdy` asserts in the same cycle as `rx_rdy`, with zero latency.
- `cmd` and `cmd_rdy` are registered. They update on the edge that accepts CHK, so they are visible 1 cycle after the CHK byte is presented.
- `chk_err` and `ovr_err` are registered and are high for exactly the cycle after the CHK byte is accepted.
- `tmo_err` is high for exactly the cycle after the expiry cycle. The state reads IDLE in that same cycle.
- Timeout boundary:
  - The last byte is accepted at edge E.
  - Expiry is evaluated in the cycle where `tmo_cnt` = `TMO_CYCLES`-1, i.e. `TMO_CYCLES` cycles after E.
  - A byte presented `TMO_CYCLES`-1 cycles after E is still in-frame.
- A sync byte in IDLE can be followed by HI as early as the next cycle. All states accept back-to-back bytes on consecutive cycles.
- The `clr_cmd_rdy` effect is visible next cycle.

## Test plan
- **Valid frame:** bytes A5, 12, 34, 26, then wait → `cmd`=16'h1234 and `cmd_rdy`=1 one cycle after the 26 byte; `chk_err`/`tmo_err`/`ovr_err` stay 0. `clr_cmd_rdy` pulse → `cmd_rdy`=0 and `cmd` stays 1234.
- **Bad checksum:** A5, 12, 34, 00 → one-cycle `chk_err`, `cmd_rdy` stays 0. A following A5, AB, CD, 66 → `cmd`=ABCD.
- **Garbage then sync:** 00, FF, 5A, then A5, 00, 01, 01 → no errors for the garbage, `cmd`=16'h0001.
- **Timeout:** A5, 12 then silence for `TMO_CYCLES` (set to 16) → `tmo_err` pulse exactly 16 cycles after the 12 byte is accepted, state back in IDLE. Next A5, 00, 02, 02 → `cmd`=0002. Byte at 15 cycles → no timeout.
- **Overrun and collision:**
  - Two valid frames without `clr_cmd_rdy` → `ovr_err` pulse on the second, `cmd`=second value.
  - Repeat with `clr_cmd_rdy` in the CHK-accept cycle → no `ovr_err`, `cmd_rdy`=1.
- **Reset mid-frame:** assert `rst` after A5, 12 → all outputs 0 next cycle, no `tmo_err`. Sending 34, 26 then yields nothing, and `clr_rdy`=0 while `rst`=1.
